// File: rtl/unidad_control_multiciclo_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU/PC selects,
// FSM states and the per-state control word decode.
package unidad_control_multiciclo_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_MEM_RD,
        S_WB_MEM, S_MEM_WR, S_WB_I, S_BRANCH, S_JUMP
    } state_t;

    // fetch/branch/store mark states whose outputs are later qualified by inputs
    typedef struct packed {
        logic       fetch;
        logic       branch;
        logic       store;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       done;
    } ctrl_t;

    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = ALUOP_ADD; end
            S_DECODE: begin c.alu_src_b = 2'b11; c.alu_op = ALUOP_ADD; end
            S_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_FUNCT; end
            S_WB_R:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            S_ADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALUOP_ADD; end
            S_MEM_RD: begin c.iord = 1'b1; c.mem_read = 1'b1; end
            S_WB_MEM: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            S_MEM_WR: begin c.store = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1; end
            S_WB_I:   begin c.reg_write = 1'b1; c.done = 1'b1; end
            S_BRANCH: begin c.branch = 1'b1; c.alu_src_a = 1'b1; c.alu_op = ALUOP_SUB;
                            c.pc_src = PCSRC_ALUOUT; c.done = 1'b1; end
            S_JUMP:   begin c.pc_src = PCSRC_JUMP; c.pc_write = 1'b1; c.done = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidad_control_multiciclo_mem_wait_timer.sv
// Memory wait counter: runs while a strobe waits, otherwise holds at zero.
module unidad_control_multiciclo_mem_wait_timer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CW          = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    output logic o_last
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_count <= '0;
        else if (i_inc) r_count <= r_count + CW'(1);
        else            r_count <= '0;
    end

    // Final permitted waiting cycle; missing MemReady here aborts the access.
    assign o_last = (r_count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS-style control unit: Moore FSM with registered control word,
// memory handshake with timeout, sticky Illegal/MemError flags.
module unidad_control_multiciclo
    import unidad_control_multiciclo_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OpCode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemToWrite,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       InstrDone,
    output logic       Illegal,
    output logic       MemError
);

    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;

    state_t r_state, w_next;
    ctrl_t  r_ctrl;
    logic   r_illegal, r_mem_error;
    logic   w_strobe, w_ready, w_last, w_expired, w_illegal_op;

    // MemReady only counts while a strobe is actually up, so it is ignored
    // outside the memory states and in the idle cycle right after reset.
    assign w_strobe  = r_ctrl.mem_read | r_ctrl.mem_write;
    assign w_ready   = w_strobe & MemReady;
    assign w_expired = w_strobe & w_last & ~MemReady;

    unidad_control_multiciclo_mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CW          (CW)
    ) u_mem_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_strobe & ~MemReady & ~w_last),
        .o_last (w_last)
    );

    always_comb begin
        w_next       = r_state;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH:  if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (OpCode)
                    OP_R:                  w_next = S_EXEC_R;
                    OP_LW, OP_SW, OP_ADDI: w_next = S_ADDR;
                    OP_BEQ:                w_next = S_BRANCH;
                    OP_J:                  w_next = S_JUMP;
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: w_next = S_WB_R;
            S_ADDR: begin
                case (OpCode)
                    OP_LW:   w_next = S_MEM_RD;
                    OP_SW:   w_next = S_MEM_WR;
                    default: w_next = S_WB_I;
                endcase
            end
            S_MEM_RD: begin
                if (w_ready)        w_next = S_WB_MEM;
                else if (w_expired) w_next = S_FETCH;
            end
            S_MEM_WR: if (w_ready || w_expired) w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Control word is decoded from the next state so outputs come straight off flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_ctrl      <= '0;
            r_illegal   <= 1'b0;
            r_mem_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_state(w_next);
            if (w_illegal_op) r_illegal   <= 1'b1;
            if (w_expired)    r_mem_error <= 1'b1;
        end
    end

    assign IRWrite    = r_ctrl.fetch & w_ready;
    assign PCWrite    = (r_ctrl.fetch & w_ready) | r_ctrl.pc_write | (r_ctrl.branch & Zero);
    assign InstrDone  = r_ctrl.done | (r_ctrl.store & w_ready);
    assign IorD       = r_ctrl.iord;
    assign MemRead    = r_ctrl.mem_read;
    assign MemToWrite = r_ctrl.mem_write;
    assign MemToReg   = r_ctrl.mem_to_reg;
    assign RegWrite   = r_ctrl.reg_write;
    assign RegDst     = r_ctrl.reg_dst;
    assign ALUSrcA    = r_ctrl.alu_src_a;
    assign ALUSrcB    = r_ctrl.alu_src_b;
    assign ALUOp      = r_ctrl.alu_op;
    assign PCSrc      = r_ctrl.pc_src;
    assign Illegal    = r_illegal;
    assign MemError   = r_mem_error;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench for unidad_control_multiciclo: per-cycle expected control
// vectors are queued with the stimulus and popped against the sampled outputs.
module tb_unidad_control_multiciclo;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC_R = 3, P_WB_R = 4,
                   P_ADDR = 5, P_MEM_RD = 6, P_WB_MEM = 7, P_MEM_WR = 8, P_WB_I = 9,
                   P_BRANCH = 10, P_JUMP = 11;

    typedef struct packed {
        logic       pcw, irw, iord, mrd, mwr, m2r, rw, rdst, asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       done, ill, merr;
    } obs_t;

    logic       clk, rst_n, Zero, MemReady;
    logic [5:0] OpCode;
    logic       PCWrite, IRWrite, IorD, MemRead, MemToWrite, MemToReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic       InstrDone, Illegal, MemError;

    obs_t obs;
    obs_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   e_ill = 1'b0;
    bit   e_merr = 1'b0;

    unidad_control_multiciclo #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemToWrite(MemToWrite), .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .InstrDone(InstrDone), .Illegal(Illegal), .MemError(MemError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Expected outputs of each phase, written from the control table.
    function automatic obs_t exp_of(input int ph, input bit rdy, input bit z);
        obs_t e;
        e = '0;
        e.ill  = e_ill;
        e.merr = e_merr;
        case (ph)
            P_FETCH:  begin e.mrd = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            P_DECODE: e.asb = 2'b11;
            P_EXEC_R: begin e.asa = 1; e.aop = 3'b010; end
            P_WB_R:   begin e.rdst = 1; e.rw = 1; e.done = 1; end
            P_ADDR:   begin e.asa = 1; e.asb = 2'b10; end
            P_MEM_RD: begin e.iord = 1; e.mrd = 1; end
            P_WB_MEM: begin e.m2r = 1; e.rw = 1; e.done = 1; end
            P_MEM_WR: begin e.iord = 1; e.mwr = 1; e.done = rdy; end
            P_WB_I:   begin e.rw = 1; e.done = 1; end
            P_BRANCH: begin e.asa = 1; e.aop = 3'b001; e.pcs = 2'b01; e.pcw = z; e.done = 1; end
            P_JUMP:   begin e.pcs = 2'b10; e.pcw = 1; e.done = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    task automatic sample_obs();
        obs = {PCWrite, IRWrite, IorD, MemRead, MemToWrite, MemToReg, RegWrite, RegDst,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, InstrDone, Illegal, MemError};
    endtask

    task automatic tick(input logic [5:0] op, input bit z, input bit rdy);
        @(negedge clk);
        OpCode = op; Zero = z; MemReady = rdy;
        #1;
        sample_obs();
    endtask

    task automatic test_reset();
        obs_t e;
        rst_n = 1'b0; OpCode = '0; Zero = 1'b0; MemReady = 1'b0;
        e_ill = 1'b0; e_merr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_of(P_IDLE, 1'b0, 1'b0));
            tick(T_R, 1'b1, 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        sb.push_back(exp_of(P_IDLE, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1; MemReady = 1'b0; Zero = 1'b0;
        #1;
        sample_obs();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
    endtask

    task automatic test_r_type();
        int   ph [4] = '{P_FETCH, P_DECODE, P_EXEC_R, P_WB_R};
        int   dones = 0;
        obs_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_of(ph[i], i == 0, 1'b0));
            tick(T_R, 1'b0, i == 0);
            e = sb.pop_front();
            dones += int'(InstrDone);
            checks++;
            if (obs !== e) begin failures++; $display("FAIL r_type cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        checks++;
        if (dones != 1) begin failures++; $display("FAIL r_type_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_lw_delayed();
        int   ph [8] = '{P_FETCH, P_DECODE, P_ADDR, P_MEM_RD, P_MEM_RD, P_MEM_RD, P_MEM_RD, P_WB_MEM};
        bit   rd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int   rd_cycles = 0;
        obs_t e;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(exp_of(ph[i], rd[i], 1'b0));
            tick(T_LW, 1'b0, rd[i]);
            e = sb.pop_front();
            if (MemRead && IorD) rd_cycles++;
            checks++;
            if (obs !== e) begin failures++; $display("FAIL lw_delayed cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        checks++;
        if (rd_cycles != 4) begin failures++; $display("FAIL lw_memread_hold got=%0d exp=4", rd_cycles); end
    endtask

    task automatic test_beq();
        int   ph [6] = '{P_FETCH, P_DECODE, P_BRANCH, P_FETCH, P_DECODE, P_BRANCH};
        bit   zz [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        obs_t e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(exp_of(ph[i], ph[i] == P_FETCH, zz[i]));
            tick(T_BEQ, zz[i], ph[i] == P_FETCH);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL beq cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    // MemReady held high as a level: ignored outside the fetch/memory states.
    task automatic test_addi_level_ready();
        int   ph [4] = '{P_FETCH, P_DECODE, P_ADDR, P_WB_I};
        obs_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_of(ph[i], 1'b1, 1'b0));
            tick(T_ADDI, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL addi cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_jump_fetch_wait();
        int   ph [5] = '{P_FETCH, P_FETCH, P_FETCH, P_DECODE, P_JUMP};
        bit   rd [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        obs_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_of(ph[i], rd[i], 1'b0));
            tick(T_J, 1'b0, rd[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL jump cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    // MemReady arrives on the last allowed wait cycle: still a successful store.
    task automatic test_sw_boundary();
        int   ph[$];
        bit   rd[$];
        obs_t e;
        ph = '{P_FETCH, P_DECODE, P_ADDR};
        rd = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 16; k++) begin ph.push_back(P_MEM_WR); rd.push_back(k == 15); end
        ph.push_back(P_FETCH); rd.push_back(1'b0);
        foreach (ph[i]) begin
            sb.push_back(exp_of(ph[i], rd[i], 1'b0));
            tick(T_SW, 1'b0, rd[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL sw_boundary cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_illegal();
        int   ph [6] = '{P_FETCH, P_DECODE, P_FETCH, P_DECODE, P_EXEC_R, P_WB_R};
        obs_t e;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) e_ill = 1'b1;
            sb.push_back(exp_of(ph[i], ph[i] == P_FETCH, 1'b0));
            tick((i < 2) ? T_BAD : T_R, 1'b0, ph[i] == P_FETCH);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL illegal cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_sw_timeout();
        int   ph[$];
        bit   rd[$];
        int   wr_cycles = 0;
        obs_t e;
        ph = '{P_FETCH, P_DECODE, P_ADDR};
        rd = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 16; k++) begin ph.push_back(P_MEM_WR); rd.push_back(1'b0); end
        ph.push_back(P_FETCH); rd.push_back(1'b0);
        foreach (ph[i]) begin
            if (i == 19) e_merr = 1'b1;
            sb.push_back(exp_of(ph[i], rd[i], 1'b0));
            tick(T_SW, 1'b0, rd[i]);
            e = sb.pop_front();
            if (MemToWrite) wr_cycles++;
            checks++;
            if (obs !== e) begin failures++; $display("FAIL sw_timeout cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        checks++;
        if (wr_cycles != 16) begin failures++; $display("FAIL sw_timeout_hold got=%0d exp=16", wr_cycles); end
    endtask

    task automatic test_reset_mid_store();
        int   ph [5] = '{P_FETCH, P_DECODE, P_ADDR, P_MEM_WR, P_MEM_WR};
        int   ph2 [3] = '{P_FETCH, P_DECODE, P_JUMP};
        obs_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_of(ph[i], i == 0, 1'b0));
            tick(T_SW, 1'b0, i == 0);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        e_ill = 1'b0; e_merr = 1'b0;
        sb.push_back(exp_of(P_IDLE, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        sample_obs();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_mid_async got=%h exp=%h", obs, e); end
        sb.push_back(exp_of(P_IDLE, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sample_obs();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_mid_release got=%h exp=%h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_of(ph2[i], i == 0, 1'b0));
            tick(T_J, 1'b0, i == 0);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_delayed();
        test_beq();
        test_addi_level_ready();
        test_jump_fetch_wait();
        test_sw_boundary();
        test_illegal();
        test_sw_timeout();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unidad_control_multiciclo.md
UNIDAD_CONTROL_MULTICICLO -- requirements
Module: unidad_control_multiciclo

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16; max cycles waited for MemReady before abort.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 OpCode  in  6  opcode field from instruction register.
REQ-005 Zero  in  1  ALU zero flag, valid in BRANCH state.
REQ-006 MemReady  in  1  memory completion handshake, one-cycle pulse or level.
REQ-007 PCWrite, IRWrite  out  1 each  PC / instruction register load enables.
REQ-008 IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemRead, MemToWrite  out  1 each  memory read / write strobes, held until MemReady.
REQ-010 MemToReg, RegWrite, RegDst  out  1 each  writeback mux, register write enable, dest select (1 = rd).
REQ-011 ALUSrcA  out  1; ALUSrcB  out  2; ALUOp  out  3 (000 add, 001 sub, 010 funct-decoded).
REQ-012 PCSrc  out  2  00 ALU result, 01 ALUOut (branch), 10 jump target.
REQ-013 InstrDone  out  1  one-cycle pulse on last cycle of each instruction.
REQ-014 Illegal, MemError  out  1 each  sticky error flags, cleared only by reset.

Function
REQ-015 Moore FSM; all outputs decoded from state register only, default 0 in every state.
REQ-016 Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-017 FETCH: IorD=0, MemRead=1; on MemReady: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=000 (PC+4), go DECODE.
REQ-018 DECODE (1 cycle): ALUSrcB=11, ALUOp=000 (branch target); next by OpCode: R->EXEC_R, LW/SW/ADDI->ADDR, BEQ->BRANCH, J->JUMP, other->FETCH with Illegal set.
REQ-019 EXEC_R: ALUSrcA=1, ALUOp=010 -> WB_R (RegDst=1, RegWrite=1, MemToReg=0, InstrDone) -> FETCH.
REQ-020 ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; LW->MEM_RD, SW->MEM_WR, ADDI->WB_I (RegDst=0, RegWrite=1, InstrDone).
REQ-021 MEM_RD: IorD=1, MemRead=1 until MemReady -> WB_MEM (RegDst=0, MemToReg=1, RegWrite=1, InstrDone) -> FETCH.
REQ-022 MEM_WR: IorD=1, MemToWrite=1 until MemReady; InstrDone on MemReady cycle -> FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUOp=001, PCSrc=01, PCWrite=Zero, InstrDone -> FETCH.
REQ-024 JUMP: PCSrc=10, PCWrite=1, InstrDone -> FETCH.
REQ-025 Instruction cycle counts with zero-wait memory (MemReady in first cycle): R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3.
REQ-026 Wait counter: 5-bit minimum, cleared on entry to FETCH/MEM_RD/MEM_WR, increments each waiting cycle.
REQ-027 Counter reaching TIMEOUT_CYC without MemReady: set MemError, drop strobes, go FETCH, no register or PC write, no InstrDone.
REQ-028 MemReady outside FETCH/MEM_RD/MEM_WR ignored; MemReady coincident with timeout cycle counts as success.
REQ-029 Illegal opcode: no RegWrite, MemToWrite or PCWrite beyond FETCH's PC+4; no InstrDone.

Reset
REQ-030 rst_n low: state=FETCH, counter=0, Illegal=MemError=0, all outputs 0 except FETCH decode suppressed until rst_n high.
REQ-031 Reset mid-instruction aborts it immediately; no pending write completes.
REQ-032 First fetch MemRead asserted on first rising clk after rst_n deasserts.

Structure
REQ-033 Shared package holds opcode constants, ALUOp encodings, PCSrc encodings and state enum.
REQ-034 Single module; wait/timeout counter is the natural sub-module: mem_wait_timer.

Verification
REQ-035 R-type 000000, MemReady immediate -> RegWrite=1, RegDst=1, ALUOp=010 in cycle 4, InstrDone once, total 4 cycles.
REQ-036 LW with MemReady delayed 3 cycles in MEM_RD -> MemRead held 4 cycles, IorD=1, then MemToReg=1, RegWrite=1.
REQ-037 BEQ with Zero=1 then Zero=0 -> PCWrite=1 with PCSrc=01 first case, PCWrite=0 second; 3 cycles each.
REQ-038 SW with MemReady never asserted, TIMEOUT_CYC=16 -> MemToWrite drops after 16 cycles, MemError=1, return to FETCH.
REQ-039 OpCode 111111 -> Illegal=1, no RegWrite/MemToWrite, next FETCH proceeds normally.
REQ-040 rst_n pulsed low during MEM_WR -> MemToWrite=0 asynchronously, state FETCH, flags cleared.
